// File: rtl/bat_loader_pkg.sv
// Shared types and constants for the BatAmateur program loader.
package bat_loader_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM, DONE, RUN, ERR} state_t;

  localparam logic [15:0] SYNC_DEFAULT = 16'hBA7A;
  localparam logic        RW_WRITE     = 1'b0;
  localparam logic        RW_READ      = 1'b1;

  // States in which the loader takes words from the stream.
  function automatic logic ready_in(state_t s);
    return !(s == DONE || s == ERR);
  endfunction

endpackage

// File: rtl/bat_loader_csum.sv
// Frame checksum accumulator: mod-2^W running sum with clear and add enable.
module bat_loader_csum #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clr) sum <= '0;
    else if (add)     sum <= sum + din;
  end

endmodule

// File: rtl/bat_program_loader.sv
// Streams a framed program image into RAM with the CPU halted, then releases HALT.
// Optional frame checksum: define LOADER_CHECKSUM_EN.
module bat_program_loader
  import bat_loader_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 16,
  parameter int                    DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = DATA_WIDTH'(SYNC_DEFAULT),
  parameter bit                    AUTO_RUN      = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DATA_WIDTH-1:0]    IN_DATA,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic                     RUN_REQ,
  output logic                     HALT,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic [DATA_WIDTH-1:0]    DATA_BUS,
  output logic                     BUS_OE,
  output logic                     LOADED,
  output logic                     LOAD_ERR
);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    rem_q;
  logic                     accept, is_sync;

  assign accept  = IN_VALID && IN_READY;
  assign is_sync = (IN_DATA == SYNC_WORD);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_NEXT = CSUM;
  logic [DATA_WIDTH-1:0] csum;
  logic                  err_q;

  bat_loader_csum #(.W(DATA_WIDTH)) u_csum (
    .clk   (CLK),
    .reset (RESET),
    .clr   (accept && is_sync && (state == IDLE || state == RUN)),
    .add   (accept && (state == ADDR || state == COUNT || state == DATA)),
    .din   (IN_DATA),
    .sum   (csum)
  );

  assign LOAD_ERR = err_q;
`else
  localparam state_t LAST_NEXT = DONE;
  assign LOAD_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      HALT        <= 1'b1;
      RAM_EN      <= 1'b0;
      RAM_RW      <= RW_READ;
      ADDRESS_BUS <= '0;
      DATA_BUS    <= '0;
      BUS_OE      <= 1'b1;
      IN_READY    <= 1'b0;
      LOADED      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q       <= 1'b0;
`endif
    end else begin
      IN_READY <= 1'b1;
      RAM_EN   <= 1'b0;
      RAM_RW   <= RW_READ;
      case (state)
        IDLE: if (accept && is_sync) state <= ADDR;
        ADDR: if (accept) begin
          addr_q <= ADDRESS_WIDTH'(IN_DATA);
          state  <= COUNT;
        end
        COUNT: if (accept) begin
          rem_q <= IN_DATA;
          if (IN_DATA == '0) begin
            state    <= LAST_NEXT;
            IN_READY <= ready_in(LAST_NEXT);
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          RAM_EN      <= 1'b1;
          RAM_RW      <= RW_WRITE;
          ADDRESS_BUS <= addr_q;
          DATA_BUS    <= IN_DATA;
          addr_q      <= addr_q + ADDRESS_WIDTH'(1);
          rem_q       <= rem_q - DATA_WIDTH'(1);
          if (rem_q == DATA_WIDTH'(1)) begin
            state    <= LAST_NEXT;
            IN_READY <= ready_in(LAST_NEXT);
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (accept) begin
          IN_READY <= 1'b0;
          if (IN_DATA == csum) state <= DONE;
          else begin
            state <= ERR;
            err_q <= 1'b1;
          end
        end
        ERR: IN_READY <= 1'b0;
`endif
        // First DONE cycle overlaps the final write pulse; LOADED rises after it.
        DONE: begin
          IN_READY <= 1'b0;
          LOADED   <= 1'b1;
          if (LOADED && (AUTO_RUN || RUN_REQ)) begin
            state    <= RUN;
            HALT     <= 1'b0;
            BUS_OE   <= 1'b0;
            IN_READY <= 1'b1;
          end
        end
        RUN: if (accept && is_sync) begin
          state  <= ADDR;
          HALT   <= 1'b1;
          BUS_OE <= 1'b1;
          LOADED <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bat_program_loader.sv
// Directed bench for bat_program_loader: one AUTO_RUN=1 instance, one AUTO_RUN=0 instance.
module tb_bat_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        run_req = 1'b0;
  logic        in_ready, halt, ram_en, ram_rw, bus_oe, loaded, load_err;
  logic [15:0] address_bus, data_bus;
  logic        rdy1, h1, en1, rw1, oe1, ld1, er1;
  logic [15:0] ab1, db1;

  int pass = 0;
  int total = 0;
  int cyc = 0;

  typedef struct {logic [15:0] a; logic [15:0] d; logic rw; int c;} wr_t;
  wr_t         wq[$];
  logic [15:0] dat [8];

  bat_program_loader #(.AUTO_RUN(1'b1)) dut0 (
    .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .RUN_REQ(run_req), .HALT(halt), .RAM_EN(ram_en), .RAM_RW(ram_rw),
    .ADDRESS_BUS(address_bus), .DATA_BUS(data_bus), .BUS_OE(bus_oe),
    .LOADED(loaded), .LOAD_ERR(load_err)
  );

  bat_program_loader #(.AUTO_RUN(1'b0)) dut1 (
    .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy1),
    .RUN_REQ(run_req), .HALT(h1), .RAM_EN(en1), .RAM_RW(rw1),
    .ADDRESS_BUS(ab1), .DATA_BUS(db1), .BUS_OE(oe1),
    .LOADED(ld1), .LOAD_ERR(er1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_en === 1'b1) wq.push_back('{address_bus, data_bus, ram_rw, cyc});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; run_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) $display("FAIL send_ready word %h: IN_READY=%b want 1", w, in_ready);
    else pass++;
    in_data = w; in_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends SYNC, address, count, dat[0..n-1] (and the checksum word when enabled).
  task automatic send_frame(input logic [15:0] a, input int n);
    logic [15:0] sum;
    send(16'hBA7A);
    send(a);
    send(16'(n));
    sum = a + 16'(n);
    for (int i = 0; i < n; i++) begin
      send(dat[i]);
      sum = sum + dat[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send(sum);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (halt !== 1'b1 || ram_en !== 1'b0 || ram_rw !== 1'b1 || address_bus !== 16'h0 ||
        data_bus !== 16'h0 || bus_oe !== 1'b1 || in_ready !== 1'b0 || loaded !== 1'b0 || load_err !== 1'b0)
      $display("FAIL reset_values got H%b E%b RW%b A%h D%h OE%b R%b L%b ER%b want H1 E0 RW1 A0000 D0000 OE1 R0 L0 ER0",
               halt, ram_en, ram_rw, address_bus, data_bus, bus_oe, in_ready, loaded, load_err);
    else pass++;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || halt !== 1'b1) $display("FAIL idle_ready got R%b H%b want R1 H1", in_ready, halt);
    else pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea [3] = '{16'h0010, 16'h0011, 16'h0012};
    logic [15:0] ed [3] = '{16'h0000, 16'h0001, 16'h0005};
    wq.delete();
    dat[0] = 16'h0000; dat[1] = 16'h0001; dat[2] = 16'h0005;
    send_frame(16'h0010, 3);
    idle();
    total++;
    if (loaded !== 1'b0 || halt !== 1'b1) $display("FAIL b2b_cycle1 got L%b H%b want L0 H1", loaded, halt);
    else pass++;
    @(negedge clk);
    total++;
    if (loaded !== 1'b1 || halt !== 1'b1) $display("FAIL b2b_cycle2 got L%b H%b want L1 H1", loaded, halt);
    else pass++;
    @(negedge clk);
    total++;
    if (halt !== 1'b0 || bus_oe !== 1'b0 || ram_en !== 1'b0) $display("FAIL b2b_run got H%b OE%b E%b want H0 OE0 E0", halt, bus_oe, ram_en);
    else pass++;
    total++;
    if (wq.size() != 3) $display("FAIL b2b_write_count got %0d want 3", wq.size());
    else begin
      pass++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wq[i].a !== ea[i] || wq[i].d !== ed[i] || wq[i].rw !== 1'b0 || wq[i].c != wq[0].c + i)
          $display("FAIL b2b_write%0d got %h<-%h rw%b c+%0d want %h<-%h rw0 c+%0d",
                   i, wq[i].a, wq[i].d, wq[i].rw, wq[i].c - wq[0].c, ea[i], ed[i], i);
        else pass++;
      end
    end
  endtask

  task automatic test_garbage();
    do_reset();
    wq.delete();
    send(16'h1234);
    send(16'h5555);
    dat[0] = 16'h0012; dat[1] = 16'h7F98;
    send_frame(16'h0000, 2);
    idle();
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 2) $display("FAIL garbage_write_count got %0d want 2", wq.size());
    else begin
      pass++;
      total++;
      if (wq[0].a !== 16'h0000 || wq[0].d !== 16'h0012 || wq[1].a !== 16'h0001 || wq[1].d !== 16'h7F98)
        $display("FAIL garbage_writes got %h<-%h %h<-%h want 0000<-0012 0001<-7f98", wq[0].a, wq[0].d, wq[1].a, wq[1].d);
      else pass++;
    end
    total++;
    if (halt !== 1'b0) $display("FAIL garbage_run got H%b want 0", halt);
    else pass++;
  endtask

  task automatic test_wrap();
    wq.delete();
    send(16'hBA7A);
    send(16'hFFFF);
    total++;
    if (halt !== 1'b1 || bus_oe !== 1'b1 || loaded !== 1'b0)
      $display("FAIL resync_from_run got H%b OE%b L%b want H1 OE1 L0", halt, bus_oe, loaded);
    else pass++;
    send(16'h0002);
    send(16'hAAAA);
    send(16'hBBBB);
`ifdef LOADER_CHECKSUM_EN
    send(16'hFFFF + 16'h0002 + 16'hAAAA + 16'hBBBB);
`endif
    idle();
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 2) $display("FAIL wrap_write_count got %0d want 2", wq.size());
    else begin
      pass++;
      total++;
      if (wq[0].a !== 16'hFFFF || wq[0].d !== 16'hAAAA || wq[1].a !== 16'h0000 || wq[1].d !== 16'hBBBB || wq[1].c != wq[0].c + 1)
        $display("FAIL wrap_writes got %h<-%h %h<-%h want ffff<-aaaa 0000<-bbbb", wq[0].a, wq[0].d, wq[1].a, wq[1].d);
      else pass++;
    end
  endtask

  task automatic test_count_zero();
    do_reset();
    wq.delete();
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    total++;
    if (h1 !== 1'b1 || rdy1 !== 1'b1) $display("FAIL runreq_in_idle got H%b R%b want H1 R1", h1, rdy1);
    else pass++;
    send_frame(16'h0040, 0);
    idle();
    repeat (2) @(negedge clk);
    total++;
    if (halt !== 1'b0 || loaded !== 1'b1) $display("FAIL count0_auto got H%b L%b want H0 L1", halt, loaded);
    else pass++;
    repeat (3) @(negedge clk);
    total++;
    if (h1 !== 1'b1 || ld1 !== 1'b1 || rdy1 !== 1'b0) $display("FAIL count0_manual_wait got H%b L%b R%b want H1 L1 R0", h1, ld1, rdy1);
    else pass++;
    total++;
    if (wq.size() != 0) $display("FAIL count0_no_write got %0d writes want 0", wq.size());
    else pass++;
    run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    total++;
    if (h1 !== 1'b0 || oe1 !== 1'b0 || rdy1 !== 1'b1) $display("FAIL count0_runreq got H%b OE%b R%b want H0 OE0 R1", h1, oe1, rdy1);
    else pass++;
  endtask

  task automatic test_gaps_and_reset();
    do_reset();
    wq.delete();
    send(16'hBA7A);
    send(16'h0100);
    send(16'h0004);
    send(16'h1111);
    idle();
    send(16'h2222);
    idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++;
    if (halt !== 1'b1 || ram_en !== 1'b0 || ram_rw !== 1'b1 || address_bus !== 16'h0 ||
        data_bus !== 16'h0 || bus_oe !== 1'b1 || in_ready !== 1'b0 || loaded !== 1'b0 || load_err !== 1'b0)
      $display("FAIL midframe_reset got H%b E%b RW%b A%h D%h OE%b R%b L%b ER%b want H1 E0 RW1 A0000 D0000 OE1 R0 L0 ER0",
               halt, ram_en, ram_rw, address_bus, data_bus, bus_oe, in_ready, loaded, load_err);
    else pass++;
    rst = 1'b0;
    total++;
    if (wq.size() != 2) $display("FAIL gaps_write_count got %0d want 2", wq.size());
    else begin
      pass++;
      total++;
      if (wq[0].a !== 16'h0100 || wq[0].d !== 16'h1111 || wq[1].a !== 16'h0101 || wq[1].d !== 16'h2222 || wq[1].c != wq[0].c + 2)
        $display("FAIL gaps_writes got %h<-%h %h<-%h gap %0d want 0100<-1111 0101<-2222 gap 2",
                 wq[0].a, wq[0].d, wq[1].a, wq[1].d, wq[1].c - wq[0].c);
      else pass++;
    end
    wq.delete();
    dat[0] = 16'h3333;
    send_frame(16'h0200, 1);
    idle();
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 1 || halt !== 1'b0) $display("FAIL reload_after_reset got %0d writes H%b want 1 H0", wq.size(), halt);
    else begin
      pass++;
      total++;
      if (wq[0].a !== 16'h0200 || wq[0].d !== 16'h3333) $display("FAIL reload_write got %h<-%h want 0200<-3333", wq[0].a, wq[0].d);
      else pass++;
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wq.delete();
    send(16'hBA7A); send(16'h0010); send(16'h0001); send(16'h0005); send(16'h0016);
    idle();
    repeat (2) @(negedge clk);
    total++;
    if (halt !== 1'b0 || load_err !== 1'b0 || wq.size() != 1) $display("FAIL csum_good got H%b ER%b W%0d want H0 ER0 W1", halt, load_err, wq.size());
    else pass++;
    send(16'hBA7A); send(16'h0010); send(16'h0001); send(16'h0005); send(16'h0017);
    idle();
    total++;
    if (load_err !== 1'b1 || halt !== 1'b1 || in_ready !== 1'b0) $display("FAIL csum_bad got ER%b H%b R%b want ER1 H1 R0", load_err, halt, in_ready);
    else pass++;
    repeat (5) @(negedge clk);
    total++;
    if (load_err !== 1'b1 || halt !== 1'b1 || loaded !== 1'b0) $display("FAIL csum_bad_sticky got ER%b H%b L%b want ER1 H1 L0", load_err, halt, loaded);
    else pass++;
    do_reset();
    total++;
    if (load_err !== 1'b0) $display("FAIL csum_err_cleared got %b want 0", load_err);
    else pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_garbage();
    test_wrap();
    test_count_zero();
    test_gaps_and_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
